// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the iterative multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on a {hi,lo} accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    logic [WIDTH:0] sum, sh, diff;
    assign sum  = {1'b0, hi} + {1'b0, (lo[0] ? m : {WIDTH{1'b0}})};
    assign sh   = {hi, lo[WIDTH-1]};
    // hi < m always holds, so a set top bit of diff means the trial subtraction borrowed
    assign diff = sh - {1'b0, m};
    assign {hi_n, lo_n} = is_div
        ? (diff[WIDTH] ? {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1})
        : {sum, lo[WIDTH-1:1]};
endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M multiply/divide unit, one op per start pulse, result with a done pulse.
module alu_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    state_e state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q, hi_n, lo_n, abs_a, abs_b, q, r, fix;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0] cnt_q;
    logic neg_p, neg_r, sa, sb, div0, ovf, special, accept;
    assign sa      = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && operandA[WIDTH-1];
    assign sb      = (op == OP_MULH || op == OP_DIV || op == OP_REM) && operandB[WIDTH-1];
    assign abs_a   = sa ? -operandA : operandA;
    assign abs_b   = sb ? -operandB : operandB;
    assign div0    = op[2] && operandB == '0;
    assign ovf     = (op == OP_DIV || op == OP_REM) && operandA == {1'b1, {(WIDTH-1){1'b0}}} && operandB == '1;
    assign special = div0 || ovf;
    assign accept  = state_q == S_IDLE && start && !flush;
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .m      (m_q),
        .hi_n   (hi_n),
        .lo_n   (lo_n)
    );
    assign prod = neg_p ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign q    = neg_p ? -lo_q : lo_q;
    assign r    = neg_r ? -hi_q : hi_q;
    assign fix  = op_q[2] ? (op_q[1] ? r : q) : (op_q == OP_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = S_IDLE;
        else
            case (state_q)
                S_IDLE:  if (start) state_d = special ? S_FIXUP : S_CALC;
                S_CALC:  if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
    end
    // Special divides preload the final quotient/remainder so FIXUP passes them through unsigned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= op;
                cnt_q <= '0;
                m_q   <= abs_b;
                hi_q  <= div0 ? operandA : '0;
                lo_q  <= div0 ? '1 : abs_a;
                neg_p <= !special && (sa ^ sb);
                neg_r <= !special && sa;
            end else if (state_q == S_CALC && !flush) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + CW'(1);
            end else if (state_q == S_FIXUP && !flush) begin
                result <= fix;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed vectors with hand-computed results, latency, flush and reset checks.
module tb_alu_muldiv_unit;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] operand_a = '0, operand_b = '0, result;
    logic busy, done;
    int n_tests = 0, n_fail = 0;
    alu_muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .operandA (operand_a),
        .operandB (operand_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; operand_a = $urandom; operand_b = $urandom;
    endtask
    // exp_lat 0 skips the latency check; poke>0 pulses start in that busy cycle
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int poke);
        int lat, busy_low;
        launch(o, a, b);
        lat = 1; busy_low = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_low++;
            start = (lat == poke);
            if (lat == poke) begin op = 3'd5; operand_a = 32'd100; operand_b = 32'd7; end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        if (exp_lat != 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_result"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask
    initial begin
        int seen_done;
        logic [31:0] prior;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 2, 0);
        run_op("divu_by0", 3'd5, 32'h10, 32'd0, 32'hFFFF_FFFF, 2, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
        run_op("start_ignored", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 10);
        run_op("remu_prior", 3'd7, 32'd100, 32'd7, 32'd2, 34, 0);
        prior = result;
        launch(3'd4, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        chk("flush_no_done", 32'(seen_done), 32'd0);
        chk("flush_result", result, prior);
        @(negedge clk);
        op = 3'd0; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_wins", {31'd0, busy}, 32'd0);
        launch(3'd0, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 3'd0, 32'd3, 32'd3, 32'd9, 34, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
